// File: rtl/gpca.sv
// gpca: single-cycle arithmetic unit with four modes selected by X and a
// root-pattern decode of B/C: multiply, square, divide and square root.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset (clears F and S)
//   X      - mode class: 0 = multiply/square, 1 = divide/square-root
//   P      - 9-bit multiplier operand (X=0 modes)
//   B      - multiplicand B[1:10] or divisor B[1:9]; B[1:2] part of root decode
//   C      - control vector; C[1:2] part of root decode
//   A      - 18-bit dividend / radicand (X=1 modes)
//   F      - registered quotient or root
//   S      - registered product, square or remainder
module gpca (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        X,
  input  logic [1:9]  P,
  input  logic [1:19] B,
  input  logic [1:19] C,
  input  logic [1:18] A,
  output logic [1:9]  F,
  output logic [1:19] S
);

  localparam int unsigned FW = 9;
  localparam int unsigned SW = 19;
  localparam int unsigned AW = 18;
  localparam int unsigned MW = 10;
  localparam int unsigned RW = 12;

  logic [FW-1:0] p_v;
  logic [SW-1:0] b_v;
  logic [SW-1:0] c_v;
  logic [AW-1:0] a_v;
  logic          root_pat;

  assign p_v = P;
  assign b_v = B;
  assign c_v = C;
  assign a_v = A;

  // Root pattern: B[1:2] = 00 and C[1:2] = 01
  assign root_pat = (b_v[SW-1:SW-2] == 2'b00) && (c_v[SW-1:SW-2] == 2'b01);

  logic [FW-1:0] f_d, f_q;
  logic [SW-1:0] s_d, s_q;

  // Shift-add array: one row per P bit; multiplicand is B[1:10] or P itself
  logic [MW-1:0] mcand;
  logic [SW-1:0] prod;
  logic [FW-1:0] p_sh;

  always_comb begin
    mcand = root_pat ? {1'b0, p_v} : b_v[SW-1:SW-MW];
    prod  = '0;
    p_sh  = '0;
    for (int i = 0; i < int'(FW); i++) begin
      p_sh = p_v >> i;
      if (p_sh[0]) prod = prod + (SW'(mcand) << i);
    end
  end

  // Restoring divider: the quotient overflows 9 bits exactly when A[1:9] >= D,
  // which also covers D = 0; otherwise the partial remainder starts below D.
  logic [FW-1:0] dvs;
  logic          div_sat;
  logic [MW-1:0] drem;
  logic [MW-1:0] dtrial;
  logic [FW-1:0] quo;
  logic [AW-1:0] a_sh;

  always_comb begin
    dvs     = b_v[SW-1:SW-FW];
    div_sat = (a_v[AW-1:AW-FW] >= dvs);
    drem    = {1'b0, a_v[AW-1:AW-FW]};
    dtrial  = '0;
    quo     = '0;
    a_sh    = '0;
    for (int i = int'(FW) - 1; i >= 0; i--) begin
      a_sh   = a_v >> i;
      dtrial = {drem[FW-1:0], a_sh[0]};
      if (dtrial >= {1'b0, dvs}) begin
        drem   = dtrial - {1'b0, dvs};
        quo    = quo | (FW'(1) << i);
      end else begin
        drem   = dtrial;
      end
    end
  end

  // Restoring square root: one row per root bit, two radicand bits per row
  logic [RW-1:0] rrem;
  logic [RW-1:0] rtrial;
  logic [FW-1:0] root;
  logic [AW-1:0] r_sh;

  always_comb begin
    rrem   = '0;
    rtrial = '0;
    root   = '0;
    r_sh   = '0;
    for (int k = int'(FW) - 1; k >= 0; k--) begin
      r_sh   = a_v >> (2 * k);
      rrem   = {rrem[RW-3:0], r_sh[1:0]};
      rtrial = {1'b0, root, 2'b01};
      if (rrem >= rtrial) begin
        rrem = rrem - rtrial;
        root = {root[FW-2:0], 1'b1};
      end else begin
        root = {root[FW-2:0], 1'b0};
      end
    end
  end

  // Result select by mode
  always_comb begin
    f_d = '0;
    s_d = '0;
    unique case ({X, root_pat})
      2'b00, 2'b01: begin
        f_d = '0;
        s_d = prod;
      end
      2'b11: begin
        f_d = root;
        s_d = SW'(rrem);
      end
      default: begin
        if (div_sat) begin
          f_d = '1;
          s_d = SW'(a_v);
        end else begin
          f_d = quo;
          s_d = SW'(drem);
        end
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q <= '0;
      s_q <= '0;
    end else begin
      f_q <= f_d;
      s_q <= s_d;
    end
  end

  assign F = f_q;
  assign S = s_q;

endmodule

// File: tb/tb_gpca.sv
// tb_gpca: self-checking bench for gpca; directed cases plus randomized
// vectors against an arithmetic reference model.
module tb_gpca;

  logic        clk;
  logic        rst_n;
  logic        x_s;
  logic [8:0]  p_s;
  logic [18:0] b_s;
  logic [18:0] c_s;
  logic [17:0] a_s;
  logic [8:0]  f_o;
  logic [18:0] s_o;

  int n_cmp;
  int n_bad;

  gpca dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X     (x_s),
    .P     (p_s),
    .B     (b_s),
    .C     (c_s),
    .A     (a_s),
    .F     (f_o),
    .S     (s_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model computed directly from the mode rules
  function automatic void model(input logic x, input logic [8:0] p,
                                input logic [18:0] b, input logic [18:0] c,
                                input logic [17:0] a,
                                output logic [8:0] f, output logic [18:0] s);
    int  m, d, r, av;
    bit  rp;
    rp = (b[18:17] == 2'b00) && (c[18:17] == 2'b01);
    av = int'(a);
    f  = 9'd0;
    s  = 19'd0;
    if (!x) begin
      m = rp ? int'(p) : int'(b >> 9);
      s = 19'(int'(p) * m);
    end else if (rp) begin
      r = 0;
      while ((r + 1) * (r + 1) <= av) r++;
      f = 9'(r);
      s = 19'(av - r * r);
    end else begin
      d = int'(b >> 10);
      if (d == 0 || av / d > 511) begin
        f = 9'h1FF;
        s = 19'(av);
      end else begin
        f = 9'(av / d);
        s = 19'(av % d);
      end
    end
  endfunction

  // Present operands between edges, then wait for the sampling edge
  task automatic drive(input logic x, input logic [8:0] p, input logic [18:0] b,
                       input logic [18:0] c, input logic [17:0] a);
    @(negedge clk);
    x_s = x; p_s = p; b_s = b; c_s = c; a_s = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 9'($urandom), 19'($urandom), 19'($urandom), 18'($urandom));
      n_cmp++;
      if ({f_o, s_o} !== 28'd0) begin
        n_bad++;
        $display("FAIL reset[%0d]: F=%0d S=%0d, want F=0 S=0", i, f_o, s_o);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic        tx [9];
    logic [8:0]  tp [9];
    logic [18:0] tb [9];
    logic [18:0] tc [9];
    logic [17:0] ta [9];
    logic [8:0]  wf [9];
    logic [18:0] ws [9];
    tx[0]=0; tp[0]=5; tb[0]=19'b1110000000000000000; tc[0]=tb[0]; ta[0]=0;     wf[0]=0;   ws[0]=4480;
    tx[1]=0; tp[1]=5; tb[1]=19'b0011111111111111111; tc[1]=19'b0100000000000000000; ta[1]=0; wf[1]=0; ws[1]=25;
    tx[2]=1; tp[2]=0; tb[2]=tb[1]; tc[2]=tc[1]; ta[2]=25;                       wf[2]=5;   ws[2]=0;
    tx[3]=1; tp[3]=0; tb[3]=tb[1]; tc[3]=tc[1]; ta[3]=26;                       wf[3]=5;   ws[3]=1;
    tx[4]=1; tp[4]=0; tb[4]=tb[1]; tc[4]=tc[1]; ta[4]=18'h3FFFF;                wf[4]=511; ws[4]=1022;
    tx[5]=1; tp[5]=0; tb[5]=19'b1010000000000000000; tc[5]=tb[5]; ta[5]=784;    wf[5]=2;   ws[5]=144;
    tx[6]=1; tp[6]=0; tb[6]={9'd5, 10'd0}; tc[6]=tb[6]; ta[6]=35;               wf[6]=7;   ws[6]=0;
    tx[7]=1; tp[7]=0; tb[7]={9'd0, 10'h155}; tc[7]=tb[7]; ta[7]=18'd12345;      wf[7]=9'h1FF; ws[7]=12345;
    tx[8]=0; tp[8]=9'h1FF; tb[8]={10'h3FF, 9'd0}; tc[8]=0; ta[8]=18'h3FFFF;     wf[8]=0;   ws[8]=511*1023;
    for (int i = 0; i < 9; i++) begin
      drive(tx[i], tp[i], tb[i], tc[i], ta[i]);
      n_cmp++;
      if (f_o !== wf[i] || s_o !== ws[i]) begin
        n_bad++;
        $display("FAIL directed[%0d]: F=%0d S=%0d, want F=%0d S=%0d", i, f_o, s_o, wf[i], ws[i]);
      end
    end
  endtask

  task automatic test_div_boundaries();
    logic [17:0] ta [4];
    logic [8:0]  td [4];
    logic [8:0]  wf [4];
    logic [18:0] ws [4];
    ta[0]=511;   td[0]=1;   wf[0]=511;    ws[0]=0;
    ta[1]=512;   td[1]=1;   wf[1]=9'h1FF; ws[1]=512;
    ta[2]=18'(511*300+299); td[2]=300; wf[2]=511; ws[2]=299;
    ta[3]=18'(512*300); td[3]=300; wf[3]=9'h1FF; ws[3]=512*300;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 9'($urandom), {td[i], 10'($urandom)}, 19'd0, ta[i]);
      n_cmp++;
      if (f_o !== wf[i] || s_o !== ws[i]) begin
        n_bad++;
        $display("FAIL div_bound[%0d]: F=%0d S=%0d, want F=%0d S=%0d", i, f_o, s_o, wf[i], ws[i]);
      end
    end
  endtask

  // Random operands for a chosen mode (bit0 = root pattern, bit1 = X)
  task automatic gen(input int mode, output logic x, output logic [8:0] p,
                     output logic [18:0] b, output logic [18:0] c, output logic [17:0] a);
    int d;
    x = 1'(mode >> 1);
    p = 9'($urandom);
    b = 19'($urandom);
    c = 19'($urandom);
    a = 18'($urandom);
    if (mode[0]) begin
      b[18:17] = 2'b00;
      c[18:17] = 2'b01;
    end else if (b[18:17] == 2'b00 && c[18:17] == 2'b01) begin
      c[18:17] = 2'b10;
    end
    if (x && !mode[0] && ($urandom % 2 == 0)) begin
      d = int'(b >> 10);
      a = 18'($urandom % (512 * d + 1));
    end
  endtask

  task automatic test_back_to_back();
    logic        x;
    logic [8:0]  p, ef;
    logic [18:0] b, c, es;
    logic [17:0] a;
    for (int i = 0; i < 40; i++) begin
      gen(i % 4, x, p, b, c, a);
      model(x, p, b, c, a, ef, es);
      drive(x, p, b, c, a);
      n_cmp++;
      if (f_o !== ef || s_o !== es) begin
        n_bad++;
        $display("FAIL b2b[%0d] mode %0d: F=%0d S=%0d, want F=%0d S=%0d", i, i % 4, f_o, s_o, ef, es);
      end
    end
  endtask

  task automatic test_random();
    logic        x;
    logic [8:0]  p, ef;
    logic [18:0] b, c, es;
    logic [17:0] a;
    for (int i = 0; i < 300; i++) begin
      gen(int'($urandom % 4), x, p, b, c, a);
      model(x, p, b, c, a, ef, es);
      drive(x, p, b, c, a);
      n_cmp++;
      if (f_o !== ef || s_o !== es) begin
        n_bad++;
        $display("FAIL random[%0d]: X=%0d P=%0d B=%h C=%h A=%0d F=%0d S=%0d, want F=%0d S=%0d",
                 i, x, p, b, c, a, f_o, s_o, ef, es);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic        x;
    logic [8:0]  p, ef;
    logic [18:0] b, c, es;
    logic [17:0] a;
    drive(1'b0, 9'd7, {10'd9, 9'd0}, 19'd0, 18'd0);
    n_cmp++;
    if (s_o !== 19'd63) begin
      n_bad++;
      $display("FAIL mid_pre: S=%0d, want 63", s_o);
    end
    rst_n = 1'b0;
    drive(1'b1, 9'd0, {9'd3, 10'd0}, 19'd0, 18'd100);
    n_cmp++;
    if ({f_o, s_o} !== 28'd0) begin
      n_bad++;
      $display("FAIL mid_rst: F=%0d S=%0d, want 0 0", f_o, s_o);
    end
    rst_n = 1'b1;
    gen(3, x, p, b, c, a);
    model(x, p, b, c, a, ef, es);
    drive(x, p, b, c, a);
    n_cmp++;
    if (f_o !== ef || s_o !== es) begin
      n_bad++;
      $display("FAIL mid_post: F=%0d S=%0d, want F=%0d S=%0d", f_o, s_o, ef, es);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    x_s = 1'b0; p_s = '0; b_s = '0; c_s = '0; a_s = '0;
    test_reset();
    test_directed();
    test_div_boundaries();
    test_back_to_back();
    test_random();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpca.md
GPCA -- requirements
Module: gpca

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 X  input  1  mode class: 0 = multiply/square, 1 = divide/square-root.
REQ-005 P  input  [1:9]  9-bit unsigned operand, P[1] MSB, right-justified.
REQ-006 B  input  [1:19]  operand/control vector, B[1] MSB.
REQ-007 C  input  [1:19]  control vector, C[1] MSB.
REQ-008 A  input  [1:18]  18-bit unsigned operand, A[1] MSB, right-justified.
REQ-009 F  output  [1:9]  registered quotient or root, F[1] MSB.
REQ-010 S  output  [1:19]  registered product, square or remainder, S[1] MSB.
REQ-011 The block SHALL have no parameters.

Function
REQ-012 On each rising clk edge with rst_n=1, the block SHALL sample X, P, B, C and A, then load F and S from the decoded operation, giving a latency of exactly 1 cycle.
REQ-013 The block SHALL accept new operands every cycle (no handshake) and SHALL hold F and S between edges.
REQ-014 A root-pattern input SHALL be defined as B[1:2]=00 and C[1:2]=01; the remaining bits of B and C are don't-care for root-pattern decode.
REQ-015 Multiply mode SHALL apply when X=0 and the input is not root-pattern.
- M = B[1:10], a 10-bit unsigned value.
- S = P*M as a 19-bit unsigned product (it cannot overflow).
- F = 0.
REQ-016 Square mode SHALL apply when X=0 and the input is root-pattern.
- S = P*P, zero-extended to 19 bits.
- F = 0.
REQ-017 Square-root mode SHALL apply when X=1 and the input is root-pattern.
- F = floor(sqrt(A)), 9 bits.
- S = A - F*F, zero-extended to 19 bits.
REQ-018 Divide mode SHALL apply when X=1 and the input is not root-pattern.
- D = B[1:9], a 9-bit unsigned divisor.
- F = floor(A/D).
- S = A mod D, zero-extended to 19 bits.
REQ-019 Divide-by-zero (D=0) SHALL produce F=9'h1FF and S = A zero-extended to 19 bits.
REQ-020 Divide quotient overflow (A/D > 511, D≠0) SHALL saturate F=9'h1FF and set S = A zero-extended to 19 bits.
REQ-021 P SHALL be ignored in divide and square-root modes, and A SHALL be ignored in multiply and square modes.
REQ-022 Internally, the datapath SHALL be a 9-row controlled add/subtract array, one row per P bit in X=0 modes and one row per result bit in X=1 modes (restoring algorithm), fully combinational between the input sample and the output registers.
REQ-023 All outputs SHALL be free of X/undefined values for any defined input combination.

Reset
REQ-024 When rst_n=0 at a rising clk edge, the block SHALL set F=0 and S=0, overriding any operation in progress.
REQ-025 The first valid result after reset release SHALL appear 1 cycle after the first edge with rst_n=1.
REQ-026 Asserting reset mid-stream SHALL discard the operands sampled at that edge, and no stale result SHALL reappear after release.

Verification
REQ-027 Reset: hold rst_n=0 for 2 cycles with arbitrary inputs -> F=0 and S=0 on each of those edges.
REQ-028 Multiply: X=0, P=5, B=19'b1110000000000000000, C=B, A=0 -> one cycle later S=4480 (35<<7) and F=0.
REQ-029 Square: X=0, P=5, B=19'b0011111111111111111, C=19'b0100000000000000000, A=0 -> S=25 and F=0.
REQ-030 Square-root: X=1, P=0, A=25, B and C as in REQ-029 -> F=5 and S=0; also A=26 -> F=5 and S=1; also A=18'h3FFFF -> F=511 and S=1022.
REQ-031 Divide: X=1, A=784, B=19'b1010000000000000000 (D=320), C=B -> F=2 and S=144; also A=35 with B[1:9]=5 -> F=7 and S=0; also D=0 -> F=9'h1FF and S=A.
REQ-032 Back-to-back: change the mode every cycle across all four modes with no idle cycles -> each result appears exactly 1 cycle after its operands, with no cross-talk between consecutive operations.
